// File: rtl/csr_file_if.sv
// Bundle of the CSR file's pipeline-facing signals: memory-stage read port,
// commit-stage write/trap/return strobes, raw interrupt lines and vectors to fetch/writeback.
interface csr_file_if;
  // Strobes (csr_write, traped, mret, retired) are single-cycle commits with no
  // back-pressure: every cycle a strobe is high at the rising edge takes effect.
  logic [11:0] read_address;
  logic [31:0] read_data;
  logic        csr_write;
  logic [11:0] csr_address;
  logic [31:0] csr_data;
  logic        traped;
  logic        mret;
  logic        retired;
  logic [3:0]  ecause;
  logic        interupt;
  logic [31:0] ecp;
  logic        ext_irq;
  logic        timer_irq;
  logic        soft_irq;
  logic        eip;
  logic        tip;
  logic        sip;
  logic [31:0] trap_vector;
  logic [31:0] mret_vector;

  modport master (
    output read_address, csr_write, csr_address, csr_data, traped, mret, retired,
           ecause, interupt, ecp, ext_irq, timer_irq, soft_irq,
    input  read_data, eip, tip, sip, trap_vector, mret_vector
  );

  modport slave (
    input  read_address, csr_write, csr_address, csr_data, traped, mret, retired,
           ecause, interupt, ecp, ext_irq, timer_irq, soft_irq,
    output read_data, eip, tip, sip, trap_vector, mret_vector
  );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file for a single-hart RV32I core: trap state, interrupt
// enables/pending, 64-bit cycle and retired-instruction counters.
module csr_file #(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
   parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
   input logic       clk,
   input logic       reset,
   csr_file_if.slave bus
);

   logic        mstatus_mie, mstatus_mpie;
   logic        mie_meie, mie_mtie, mie_msie;
   logic        mip_meip, mip_mtip, mip_msip;
   logic [31:0] mtvec, mscratch, mepc, mcause;
   logic [63:0] mcycle, minstret;
   logic [63:0] mcycle_next, minstret_next;
   logic        wr_en;

   // A trap or mret in the same cycle swallows the CSR write entirely.
   assign wr_en = bus.csr_write & ~bus.traped & ~bus.mret;

   always_comb begin
      mcycle_next   = mcycle + 64'd1;
      minstret_next = minstret + {63'd0, bus.retired};
      if (wr_en) begin
         case (bus.csr_address)
            12'hB00: mcycle_next   = {mcycle[63:32], bus.csr_data};
            12'hB80: mcycle_next   = {bus.csr_data, mcycle[31:0]};
            12'hB02: minstret_next = {minstret[63:32], bus.csr_data};
            12'hB82: minstret_next = {bus.csr_data, minstret[31:0]};
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.read_data = 32'h0;
      case (bus.read_address)
         12'h300: bus.read_data = {24'h0, mstatus_mpie, 3'b000, mstatus_mie, 3'b000};
         12'h301: bus.read_data = MISA_VALUE;
         12'h304: bus.read_data = {20'h0, mie_meie, 3'b000, mie_mtie, 3'b000, mie_msie, 3'b000};
         12'h305: bus.read_data = mtvec;
         12'h340: bus.read_data = mscratch;
         12'h341: bus.read_data = mepc;
         12'h342: bus.read_data = mcause;
         12'h344: bus.read_data = {20'h0, mip_meip, 3'b000, mip_mtip, 3'b000, mip_msip, 3'b000};
         12'hB00, 12'hC00: bus.read_data = mcycle[31:0];
         12'hB80, 12'hC80: bus.read_data = mcycle[63:32];
         12'hB02, 12'hC02: bus.read_data = minstret[31:0];
         12'hB82, 12'hC82: bus.read_data = minstret[63:32];
         default: bus.read_data = 32'h0;
      endcase
   end

   assign bus.eip         = mip_meip & mie_meie & mstatus_mie;
   assign bus.tip         = mip_mtip & mie_mtie & mstatus_mie;
   assign bus.sip         = mip_msip & mie_msie & mstatus_mie;
   assign bus.trap_vector = mtvec;
   assign bus.mret_vector = mepc;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mstatus_mie  <= 1'b0;
         mstatus_mpie <= 1'b0;
         mie_meie     <= 1'b0;
         mie_mtie     <= 1'b0;
         mie_msie     <= 1'b0;
         mip_meip     <= 1'b0;
         mip_mtip     <= 1'b0;
         mip_msip     <= 1'b0;
         mtvec        <= MTVEC_RESET;
         mscratch     <= 32'h0;
         mepc         <= 32'h0;
         mcause       <= 32'h0;
         mcycle       <= 64'h0;
         minstret     <= 64'h0;
      end else begin
         mip_meip <= bus.ext_irq;
         mip_mtip <= bus.timer_irq;
         mip_msip <= bus.soft_irq;
         mcycle   <= mcycle_next;
         minstret <= minstret_next;
         if (bus.traped) begin
            mepc         <= {bus.ecp[31:2], 2'b00};
            mcause       <= {bus.interupt, 27'h0, bus.ecause};
            mstatus_mpie <= mstatus_mie;
            mstatus_mie  <= 1'b0;
         end else if (bus.mret) begin
            mstatus_mie  <= mstatus_mpie;
            mstatus_mpie <= 1'b1;
         end else if (bus.csr_write) begin
            case (bus.csr_address)
               12'h300: begin
                  mstatus_mie  <= bus.csr_data[3];
                  mstatus_mpie <= bus.csr_data[7];
               end
               12'h304: begin
                  mie_msie <= bus.csr_data[3];
                  mie_mtie <= bus.csr_data[7];
                  mie_meie <= bus.csr_data[11];
               end
               12'h305: mtvec    <= {bus.csr_data[31:2], 2'b00};
               12'h340: mscratch <= bus.csr_data;
               12'h341: mepc     <= {bus.csr_data[31:2], 2'b00};
               // Only the interrupt flag and the 4-bit cause code are implemented.
               12'h342: mcause   <= {bus.csr_data[31], 27'h0, bus.csr_data[3:0]};
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter MTVEC_RESET, default 32'h0000_0000, reset value of mtvec.
REQ-002 Parameter MISA_VALUE, default 32'h4000_0100, constant read value of misa (RV32I).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 read_address  input  12  CSR address for the combinational read port (from the memory stage).
REQ-006 read_data  output  32  combinational read value at read_address.
REQ-007 csr_write  input  1  commit a CSR write this cycle.
REQ-008 csr_address  input  12  CSR write address.
REQ-009 csr_data  input  32  CSR write data.
REQ-010 traped  input  1  trap entry this cycle.
REQ-011 mret  input  1  return from trap this cycle.
REQ-012 retired  input  1  one instruction retired this cycle.
REQ-013 ecause  input  4  trap cause code.
REQ-014 interupt  input  1  trap is an interrupt.
REQ-015 ecp  input  32  PC of the trapping instruction, saved to mepc.
REQ-016 ext_irq, timer_irq, soft_irq  input  1 each  raw interrupt request lines.
REQ-017 eip, tip, sip  output  1 each  enabled, pending, globally allowed interrupts (to writeback).
REQ-018 trap_vector  output  32  current mtvec (to fetch).
REQ-019 mret_vector  output  32  current mepc (to fetch).

Function
REQ-020 Map: mstatus 0x300 (MIE bit3, MPIE bit7, all other bits read 0), misa 0x301, mie 0x304 (MSIE bit3, MTIE bit7, MEIE bit11), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mip 0x344 (MSIP bit3, MTIP bit7, MEIP bit11), mcycle/mcycleh 0xB00/0xB80, minstret/minstreth 0xB02/0xB82, cycle/instret/cycleh/instreth 0xC00/0xC02/0xC80/0xC82 (read-only aliases), mhartid 0xF14 = 0.
REQ-021 Unmapped addresses read 0; writes to unmapped, read-only (misa, mhartid, 0xCxx, mip) addresses are ignored.
REQ-022 Writes store only implemented bits; mtvec[1:0] and mepc[1:0] forced to 0 (direct mode only).
REQ-023 mip bits are registered copies of the irq lines, updated every cycle (one-cycle latency from line to mip).
REQ-024 eip = mip.MEIP & mie.MEIE & mstatus.MIE; tip and sip likewise; combinational from registers.
REQ-025 Trap (traped=1): mepc <= {ecp[31:2],2'b00}; mcause <= {interupt, 27'b0, ecause}; MPIE <= MIE; MIE <= 0.
REQ-026 mret (traped=0): MIE <= MPIE; MPIE <= 1.
REQ-027 Same-cycle priority: traped > mret > csr_write; a lower-priority event is fully dropped.
REQ-028 mcycle (64-bit) increments by 1 every cycle; wraps 2^64-1 -> 0.
REQ-029 minstret (64-bit) increments by 1 when retired=1; wraps likewise.
REQ-030 Write to a counter half replaces that half that cycle; the increment is suppressed for the whole 64-bit counter that cycle.
REQ-031 read_data returns pre-update values; writes become visible the following cycle.
REQ-032 trap_vector = mtvec; mret_vector = mepc; both registered values, no bypass.

Reset
REQ-033 On reset assertion, immediately: mstatus, mie, mip, mscratch, mepc, mcause, mcycle, minstret = 0; mtvec = MTVEC_RESET.
REQ-034 During reset: eip/tip/sip = 0, trap_vector = MTVEC_RESET, mret_vector = 0; all inputs ignored.
REQ-035 Reset mid-trap or mid-write discards that update; first counting edge after deassertion sets mcycle = 1.

Verification
REQ-036 Write 0x305 = 32'h0000_1003 -> next cycle read 0x305 = 32'h0000_1000, trap_vector = 32'h0000_1000.
REQ-037 MIE=1, MEIE=1, ext_irq=1 -> eip=1 one cycle later; traped=1, interupt=1, ecause=11, ecp=0x80 -> mcause=0x8000_000B, mepc=0x80, MIE=0, MPIE=1, eip=0.
REQ-038 After REQ-037, mret=1 -> MIE=1, MPIE=1, mret_vector=0x80.
REQ-039 Same cycle traped=1 and csr_write to 0x340 = 0xDEAD_BEEF -> mscratch unchanged; trap state updated.
REQ-040 Write mcycle=0xFFFF_FFFF, mcycleh=0xFFFF_FFFF on consecutive cycles -> following cycle mcycle reads 0, mcycleh 0 (wrap).
REQ-041 retired=1 for 5 cycles, reset pulse mid-sequence -> minstret = 0 during reset, counts only post-reset retirements.
